// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: unsigned/signed, full width or byte (half) width operands.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; divide is always iterative.
module muldiv_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 wide,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cy,
    output logic                 v,
    output logic                 div_error
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;
    state_e state_q, state_d;

    logic [1:0]     op_q;
    logic           wide_q, sgn_a_q, sgn_b_q, ovf_q;
    logic [W-1:0]   opd_q, sh_q, rem_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] result_q;
    logic           cy_q, div_error_q;

    // Operands become magnitudes at the accept edge; signs are kept aside for the fixup.
    logic           accept, s_a, s_dvd, s_b;
    logic [W-1:0]   in_mask_n, a_mag, b_mag;
    logic [2*W-1:0] in_mask_2n, d_mag;

    always_comb begin
        accept     = start && (state_q == StIdle || state_q == StDone);
        in_mask_n  = wide ? {W{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
        in_mask_2n = wide ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}};
        s_a        = op[0] & (wide ? a[W-1] : a[H-1]);
        s_dvd      = op[0] & (wide ? a[2*W-1] : a[W-1]);
        s_b        = op[0] & (wide ? b[W-1] : b[H-1]);
        a_mag      = (s_a ? -a[W-1:0] : a[W-1:0]) & in_mask_n;
        b_mag      = (s_b ? -b : b) & in_mask_n;
        d_mag      = (s_dvd ? -a : a) & in_mask_2n;
    end

    // One iteration step; multiplier and dividend-low are left-justified so bit W-1 is next.
    logic           is_mul, is_signed, last, first, pre_err, mul_now, ge;
    logic [W:0]     rem_sh, rem_sub;
    logic [2*W-1:0] acc_step, prod_mag;

    always_comb begin
        is_mul    = ~op_q[1];
        is_signed = op_q[0];
        last      = cnt_q == (wide_q ? CW'(W - 1) : CW'(H - 1));
        first     = cnt_q == '0;
        rem_sh    = {rem_q, sh_q[W-1]};
        rem_sub   = rem_sh - {1'b0, opd_q};
        ge        = rem_sh >= {1'b0, opd_q};
        acc_step  = {acc_q[2*W-2:0], 1'b0} + (sh_q[W-1] ? {{W{1'b0}}, opd_q} : '0);
        pre_err   = ~is_mul & first & ((opd_q == '0) | (~is_signed & (rem_q >= opd_q)));
`ifdef MULDIV_FAST_MUL_EN
        prod_mag  = {{W{1'b0}}, opd_q} * {{W{1'b0}}, (wide_q ? sh_q : (sh_q >> H))};
        mul_now   = is_mul;
`else
        prod_mag  = acc_q;
        mul_now   = 1'b0;
`endif
    end

    // Sign application and flag generation for the final result.
    logic [W-1:0]   mask_n, q_mag, r_mag, q_val, r_val, q_lim;
    logic [2*W-1:0] mask_2n, prod_val, div_res;
    logic           mul_cy, q_neg, q_ovf;

    always_comb begin
        mask_n   = wide_q ? {W{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
        mask_2n  = wide_q ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}};
        prod_val = ((sgn_a_q ^ sgn_b_q) ? -prod_mag : prod_mag) & mask_2n;
        if (!is_signed) begin
            mul_cy = wide_q ? |prod_val[2*W-1:W] : |prod_val[W-1:H];
        end else if (wide_q) begin
            mul_cy = ~(&prod_val[2*W-1:W-1] | ~|prod_val[2*W-1:W-1]);
        end else begin
            mul_cy = ~(&prod_val[W-1:H-1] | ~|prod_val[W-1:H-1]);
        end
        q_mag   = sh_q & mask_n;
        r_mag   = rem_q & mask_n;
        q_neg   = sgn_a_q ^ sgn_b_q;
        q_val   = (q_neg ? -q_mag : q_mag) & mask_n;
        r_val   = (sgn_a_q ? -r_mag : r_mag) & mask_n;
        div_res = wide_q ? {r_val, q_val} : {{W{1'b0}}, r_val[H-1:0], q_val[H-1:0]};
        q_lim   = wide_q ? {1'b1, {(W-1){1'b0}}} : {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
        // Negative quotients may reach -2^(N-1); positive ones stop at 2^(N-1)-1.
        q_ovf   = is_signed & (ovf_q | (q_neg ? (q_mag > q_lim) : (q_mag >= q_lim)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc: begin
                if (pre_err || mul_now) state_d = StDone;
                else if (last)          state_d = StFixup;
            end
            StFixup: state_d = StDone;
            StDone:  state_d = start ? StCalc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StCalc) || (state_q == StFixup);
        done      = (state_q == StDone);
        result    = result_q;
        cy        = cy_q;
        v         = cy_q;
        div_error = div_error_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            wide_q      <= 1'b0;
            sgn_a_q     <= 1'b0;
            sgn_b_q     <= 1'b0;
            ovf_q       <= 1'b0;
            opd_q       <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            cy_q        <= 1'b0;
            div_error_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            wide_q  <= wide;
            sgn_b_q <= s_b;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            if (op[1]) begin
                sgn_a_q <= s_dvd;
                opd_q   <= b_mag;
                rem_q   <= wide ? d_mag[2*W-1:W] : {{H{1'b0}}, d_mag[W-1:H]};
                sh_q    <= wide ? d_mag[W-1:0] : {d_mag[H-1:0], {H{1'b0}}};
            end else begin
                sgn_a_q <= s_a;
                opd_q   <= a_mag;
                rem_q   <= '0;
                sh_q    <= wide ? b_mag : {b_mag[H-1:0], {H{1'b0}}};
            end
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + CW'(1);
            if (is_mul) begin
                acc_q <= acc_step;
                sh_q  <= sh_q << 1;
            end else begin
                rem_q <= ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
                sh_q  <= {sh_q[W-2:0], ge};
            end
            // Signed quotient overflow is known now but only reported after fixup.
            if (first && !is_mul) ovf_q <= rem_q >= opd_q;
            if (pre_err) begin
                div_error_q <= 1'b1;
                cy_q        <= 1'b0;
            end else if (mul_now) begin
                result_q    <= prod_val;
                cy_q        <= mul_cy;
                div_error_q <= 1'b0;
            end
        end else if (state_q == StFixup) begin
            if (is_mul) begin
                result_q    <= prod_val;
                cy_q        <= mul_cy;
                div_error_q <= 1'b0;
            end else if (q_ovf) begin
                div_error_q <= 1'b1;
                cy_q        <= 1'b0;
            end else begin
                result_q    <= div_res;
                cy_q        <= 1'b0;
                div_error_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=16): directed vectors, reset corner case and
// randomized operations against an arithmetic reference model.
module tb_muldiv_seq;
    localparam int W = 16;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, start, wide;
    logic [1:0]  op;
    logic [31:0] a;
    logic [15:0] b;
    logic        busy, done, cy, v, div_error;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_prev = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .wide      (wide),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cy        (cy),
        .v         (v),
        .div_error (div_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        wide;
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        cy;
        logic        err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int mul_lat(input logic w);
        return Fast ? 2 : (w ? 18 : 10);
    endfunction

    // Reference: plain integer arithmetic on N-bit / 2N-bit operand views.
    task automatic model(input logic [1:0] o, input logic w, input logic [31:0] ai,
                         input logic [15:0] bi, output logic [31:0] res, output logic c,
                         output logic e, output int lat);
        longint n, m, an, bn, d, sa, sb, sd, p, q, r;
        n   = w ? 16 : 8;
        m   = longint'(1) << n;
        an  = longint'(ai) & (m - 1);
        bn  = longint'(bi) & (m - 1);
        d   = longint'(ai) & (m * m - 1);
        sa  = (an >= m / 2) ? an - m : an;
        sb  = (bn >= m / 2) ? bn - m : bn;
        sd  = (d >= m * m / 2) ? d - m * m : d;
        res = '0;
        c   = 1'b0;
        e   = 1'b0;
        lat = int'(n) + 2;
        case (o)
            2'd0: begin
                p   = an * bn;
                res = 32'(p);
                c   = (p >> n) != 0;
                lat = mul_lat(w);
            end
            2'd1: begin
                p   = sa * sb;
                res = 32'(p & (m * m - 1));
                c   = (p < -(m / 2)) || (p >= m / 2);
                lat = mul_lat(w);
            end
            2'd2: begin
                if (bn == 0 || d / bn >= m) begin
                    e   = 1'b1;
                    lat = 2;
                end else begin
                    res = 32'((d % bn) * m + d / bn);
                end
            end
            default: begin
                if (sb == 0) begin
                    e   = 1'b1;
                    lat = 2;
                end else begin
                    q = sd / sb;
                    r = sd % sb;
                    if (q < -(m / 2) || q >= m / 2) e = 1'b1;
                    else res = 32'((r & (m - 1)) * m + (q & (m - 1)));
                end
            end
        endcase
    endtask

    // Issues one operation (from idle or from the previous done cycle), scrambles the inputs
    // after acceptance and holds start into a busy cycle, then checks the completion.
    task automatic apply(input string tag, input logic [1:0] o, input logic w,
                         input logic [31:0] ai, input logic [15:0] bi, input logic [31:0] e_res,
                         input logic e_cy, input logic e_err, input int e_lat);
        int          lat = 0;
        logic        bad_busy = 1'b0;
        logic        bad_hold = 1'b0;
        logic [31:0] want;
        want  = e_err ? exp_prev : e_res;
        op    = o;
        wide  = w;
        a     = ai;
        b     = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        op   = 2'($urandom);
        wide = 1'($urandom);
        a    = $urandom;
        b    = 16'($urandom);
        for (int c = 1; c <= 64; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) bad_busy = 1'b1;
            if (result !== exp_prev) bad_hold = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " busy"}, {62'd0, bad_busy, busy}, 64'd0);
        check({tag, " hold"}, {63'd0, bad_hold}, 64'd0);
        check({tag, " result"}, {32'd0, result}, {32'd0, want});
        check({tag, " cy"}, {63'd0, cy}, {63'd0, e_cy & ~e_err});
        check({tag, " v"}, {63'd0, v}, {63'd0, e_cy & ~e_err});
        check({tag, " div_error"}, {63'd0, div_error}, {63'd0, e_err});
        if (!e_err) exp_prev = e_res;
    endtask

    vec_t        vecs[9];
    logic [1:0]  ro;
    logic        rw, rc, re;
    logic [31:0] ra, rr;
    logic [15:0] rb;
    int          rl;

    initial begin
        vecs[0] = '{2'd0, 1'b1, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b0, mul_lat(1)};
        vecs[1] = '{2'd1, 1'b0, 32'h00000080, 16'h0002, 32'h0000FF00, 1'b1, 1'b0, mul_lat(0)};
        vecs[2] = '{2'd2, 1'b1, 32'h00012345, 16'h0100, 32'h00450123, 1'b0, 1'b0, 18};
        vecs[3] = '{2'd3, 1'b0, 32'h0000FFF9, 16'h0002, 32'h0000FFFD, 1'b0, 1'b0, 10};
        vecs[4] = '{2'd2, 1'b1, 32'h00001234, 16'h0000, 32'h0, 1'b0, 1'b1, 2};
        vecs[5] = '{2'd2, 1'b1, 32'h00020000, 16'h0002, 32'h0, 1'b0, 1'b1, 2};
        vecs[6] = '{2'd3, 1'b0, 32'h00004000, 16'h0002, 32'h0, 1'b0, 1'b1, 10};
        vecs[7] = '{2'd3, 1'b0, 32'h0000FF80, 16'h0001, 32'h00000080, 1'b0, 1'b0, 10};
        vecs[8] = '{2'd3, 1'b0, 32'h0000FF80, 16'h00FF, 32'h0, 1'b0, 1'b1, 10};

        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        wide    = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset cy", {63'd0, cy}, 64'd0);
        check("reset v", {63'd0, v}, 64'd0);
        check("reset div_error", {63'd0, div_error}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].cy, vecs[i].err, vecs[i].lat);
            if (i % 2 == 1) begin
                @(posedge clk);
                #1;
            end
        end

        // Asynchronous reset in cycle 5 of a signed divide.
        op    = 2'd3;
        wide  = 1'b1;
        a     = 32'hFFFFF000;
        b     = 16'h0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset busy", {63'd0, busy}, 64'd0);
        check("mid reset done", {63'd0, done}, 64'd0);
        check("mid reset result", {32'd0, result}, 64'd0);
        check("mid reset cy", {63'd0, cy}, 64'd0);
        check("mid reset v", {63'd0, v}, 64'd0);
        check("mid reset div_error", {63'd0, div_error}, 64'd0);
        exp_prev = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply("mulu3x5", 2'd0, 1'b1, 32'd3, 16'd5, 32'd15, 1'b0, 1'b0, mul_lat(1));

        for (int i = 0; i < 200; i++) begin
            ro = 2'($urandom);
            rw = 1'($urandom);
            ra = $urandom;
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ra = rw ? {16'h0, ra[15:0]} : {24'h0, ra[7:0]};
                1:       ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 15);
            model(ro, rw, ra, rb, rr, rc, re, rl);
            apply($sformatf("rand%0d", i), ro, rw, ra, rb, rr, rc, re, rl);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 16, sets the full operand width W; it SHALL be even and at least 8.
REQ-002 Port: clk, input, 1 bit; the single clock, rising-edge.
REQ-003 Port: reset_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 Port: start, input, 1 bit; requests an operation and SHALL be accepted only when busy=0.
REQ-005 Port: op, input, 2 bits; 00=MULU, 01=MUL (signed), 10=DIVU, 11=DIV (signed).
REQ-006 Port: wide, input, 1 bit; 1 selects N=W, 0 selects byte mode N=W/2.
REQ-007 Port: a, input, 2W bits; low N bits are the multiplicand, low 2N bits are the dividend.
REQ-008 Port: b, input, W bits; low N bits are the multiplier or divisor.
REQ-009 Port: busy, output, 1 bit; high while an operation is in progress.
REQ-010 Port: done, output, 1 bit; one-cycle completion pulse.
REQ-011 Port: result, output, 2W bits; multiply gives the 2N-bit product; divide gives {remainder[N], quotient[N]}; bits above 2N are zero.
REQ-012 Port: cy, output, 1 bit; multiply overflow flag.
REQ-013 Port: v, output, 1 bit; multiply overflow flag, same value as cy.
REQ-014 Port: div_error, output, 1 bit; set for divide-by-zero or quotient overflow.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIXUP and DONE; start in IDLE or DONE SHALL go to CALC; the error pre-check SHALL go directly to DONE; CALC SHALL go to FIXUP after N iterations; FIXUP SHALL go to DONE; DONE SHALL go to IDLE.
REQ-016 a, b, op and wide SHALL be latched at the accept edge (cycle 0); input changes afterwards SHALL be ignored.
REQ-017 Iterative path: one bit per cycle (shift-add multiply, restoring divide), N cycles, done at cycle N+2.
REQ-018 busy SHALL be 1 in cycles 1..N+1, and done=1 with busy=0 at cycle N+2.
REQ-019 start asserted in the done cycle SHALL be accepted; start while busy=1 SHALL be ignored with no effect.
REQ-020 Signed operations SHALL convert operands to magnitudes before CALC; FIXUP SHALL apply signs.
REQ-021 Signed division SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign.
REQ-022 MULU: cy=v=1 iff product[2N-1:N] is nonzero.
REQ-023 MUL: cy=v=1 iff product[2N-1:N] is not the sign extension of product[N-1].
REQ-024 Divide: cy=v=0.
REQ-025 Divide pre-check in cycle 1: divisor=0, or DIVU with dividend[2N-1:N] >= divisor, SHALL give div_error=1 and done at cycle 2.
REQ-026 Signed quotient outside [-2^(N-1), 2^(N-1)-1], detected in FIXUP, SHALL give div_error=1 with done at N+2.
REQ-027 On div_error, result SHALL hold its previous value.
REQ-028 result, cy, v and div_error SHALL update only in the done cycle and hold until the next done.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE with busy=0, done=0, result=0, cy=0, v=0 and div_error=0, including mid-operation.
REQ-030 The first start after reset release SHALL behave as from idle.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: MULU/MUL product SHALL be computed combinationally in CALC in one cycle, done at cycle 2 after the accept edge (busy=1 cycle 1).
REQ-032 Macro MULDIV_FAST_MUL_EN undefined: multiply SHALL be iterative per REQ-017; divide SHALL be iterative in both builds.

Verification
REQ-033 W=16, MULU wide, a=0xFFFF, b=0xFFFF -> result=0xFFFE0001, cy=v=1, done at cycle 18 (cycle 2 with MULDIV_FAST_MUL_EN).
REQ-034 MUL byte, a=0x80, b=0x02 -> result=0x0000FF00, cy=v=1.
REQ-035 DIVU wide, a=0x00012345, b=0x0100 -> result=0x00450123, div_error=0, done at cycle 18.
REQ-036 DIV byte, a=0xFFF9, b=0x02 -> result=0x0000FFFD (remainder -1, quotient -3), div_error=0, done at cycle 10.
REQ-037 DIVU b=0 -> div_error=1 at cycle 2, result unchanged; DIVU wide a=0x00020000, b=0x0002 -> div_error=1 at cycle 2.
REQ-038 reset_n low at cycle 5 of a DIV -> busy=0, done=0, outputs=0 immediately; a following MULU 3x5 -> result=15.
